// File: rtl/reg_bus_arbiter.sv
// Two-requester register bus arbiter. Round-robin grant, one downstream
// transfer at a time, with an optional response timeout.
module reg_bus_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_valid,
  input  logic        m0_read,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic [7:0]  m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,

  input  logic        m1_valid,
  input  logic        m1_read,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic [7:0]  m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,

  output logic        s_valid,
  output logic        s_read,
  output logic [15:0] s_addr,
  output logic [7:0]  s_wdata,
  input  logic [7:0]  s_rdata,
  input  logic        s_ready,
  input  logic        s_err,

  output logic [1:0]  grant
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrate and capture on the next edge
  // BUSY  | downstream request driven from captured fields, timeout counting
  // DONE  | one-cycle completion pulse to the owner
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = TIMEOUT[15:0];

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_owner;
  logic        r_last;
  logic        r_read;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        r_err;
  logic [15:0] r_cnt;

  logic        w_any;
  logic        w_win;
  logic [15:0] w_cnt_inc;
  logic        w_timeout;
  logic        w_busy;
  logic        w_done;

  assign w_any     = m0_valid | m1_valid;
  // On contention the requester not served last wins; otherwise whoever asks.
  assign w_win     = (m0_valid & m1_valid) ? ~r_last : m1_valid;
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == LP_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_ready || w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_read  <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_err   <= 1'b0;
      r_cnt   <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_read  <= w_win ? m1_read  : m0_read;
            r_addr  <= w_win ? m1_addr  : m0_addr;
            r_wdata <= w_win ? m1_wdata : m0_wdata;
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
            r_cnt   <= 16'h0000;
          end
        end
        BUSY: begin
          r_cnt <= w_cnt_inc;
          // A real response beats a timeout landing in the same cycle.
          if (s_ready) begin
            r_rdata <= s_rdata;
            r_err   <= s_err;
          end else if (w_timeout) begin
            r_rdata <= 8'h00;
            r_err   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_busy = (r_state == BUSY);
  assign w_done = (r_state == DONE);

  assign s_valid = w_busy;
  assign s_read  = w_busy & r_read;
  assign s_addr  = w_busy ? r_addr  : 16'h0000;
  assign s_wdata = w_busy ? r_wdata : 8'h00;
  assign grant   = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

  assign m0_ready = w_done & ~r_owner;
  assign m1_ready = w_done & r_owner;
  assign m0_rdata = m0_ready ? r_rdata : 8'h00;
  assign m1_rdata = m1_ready ? r_rdata : 8'h00;
  assign m0_err   = m0_ready & r_err;
  assign m1_err   = m1_ready & r_err;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed table, hand sequences for reset and
// arbitration corners, and random traffic against a transaction-level model.
module tb_reg_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_valid, m0_read, m1_valid, m1_read;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic        s_valid, s_read;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic [7:0]  s_rdata;
  logic        s_ready, s_err;
  logic [1:0]  grant;

  int n_vec = 0;
  int n_err = 0;

  logic        req_v[2];
  logic        req_rd[2];
  logic [15:0] req_ad[2];
  logic [7:0]  req_wd[2];

  reg_bus_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_read(m0_read), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_read(m1_read), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_valid(s_valid), .s_read(s_read), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_err(s_err),
    .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic        rd;
    logic [15:0] ad;
    logic [7:0]  wd;
    int          lat;
    logic [7:0]  srd;
    logic        serr;
    int          ncyc;
    logic [7:0]  erd;
    logic        eerr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_port(input int n, input logic v, input logic rd,
                            input logic [15:0] ad, input logic [7:0] wd);
    if (n == 0) begin
      m0_valid = v; m0_read = rd; m0_addr = ad; m0_wdata = wd;
    end else begin
      m1_valid = v; m1_read = rd; m1_addr = ad; m1_wdata = wd;
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic rd,
                         input logic [15:0] ad, input logic [7:0] wd);
    req_v[n] = v; req_rd[n] = rd; req_ad[n] = ad; req_wd[n] = wd;
    drive_port(n, v, rd, ad, wd);
  endtask

  task automatic do_reset();
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    s_ready = 1'b0; s_err = 1'b0; s_rdata = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle and requests driven; returns at the
  // negedge of the completion cycle with the winner's request withdrawn.
  task automatic do_txn(input int win, input int lat, input logic [7:0] srd,
                        input logic serr, input int ncyc, input logic [7:0] erd,
                        input logic eerr, input bit scramble, input bit glitch);
    int oth;
    logic [1:0] g;
    oth = 1 - win;
    g = (win == 0) ? 2'b01 : 2'b10;
    chk("idle_s_valid", 32'(s_valid), 0);
    chk("idle_grant", 32'(grant), 0);
    s_ready = 1'($urandom_range(0, 1));
    s_rdata = 8'($urandom);
    s_err   = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      chk("busy_s_valid", 32'(s_valid), 1);
      chk("busy_grant", 32'(grant), 32'(g));
      chk("busy_s_read", 32'(s_read), 32'(req_rd[win]));
      chk("busy_s_addr", 32'(s_addr), 32'(req_ad[win]));
      chk("busy_s_wdata", 32'(s_wdata), 32'(req_wd[win]));
      chk("busy_ready", 32'({m1_ready, m0_ready}), 0);
      if (scramble)
        drive_port(win, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      if (glitch && k == 1) drive_port(oth, 1'b1, 1'b1, 16'hDEAD, 8'h00);
      if (glitch && k == 2) drive_port(oth, 1'b0, 1'b0, 16'h0000, 8'h00);
      s_ready = (k == lat);
      s_rdata = (k == lat) ? srd : 8'($urandom);
      s_err   = (k == lat) ? serr : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("done_s_valid", 32'(s_valid), 0);
    chk("done_grant", 32'(grant), 0);
    if (win == 0) begin
      chk("m0_ready", 32'(m0_ready), 1);
      chk("m0_rdata", 32'(m0_rdata), 32'(erd));
      chk("m0_err", 32'(m0_err), 32'(eerr));
      chk("m1_ready_quiet", 32'(m1_ready), 0);
      chk("m1_rdata_quiet", 32'(m1_rdata), 0);
      chk("m1_err_quiet", 32'(m1_err), 0);
    end else begin
      chk("m1_ready", 32'(m1_ready), 1);
      chk("m1_rdata", 32'(m1_rdata), 32'(erd));
      chk("m1_err", 32'(m1_err), 32'(eerr));
      chk("m0_ready_quiet", 32'(m0_ready), 0);
      chk("m0_rdata_quiet", 32'(m0_rdata), 0);
      chk("m0_err_quiet", 32'(m0_err), 0);
    end
    set_req(win, 1'b0, 1'b0, 16'h0, 8'h0);
    s_ready = 1'($urandom_range(0, 1));
    s_rdata = 8'($urandom);
    s_err   = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_s_valid"}, 32'(s_valid), 0);
    chk({nm, "_grant"}, 32'(grant), 0);
    chk({nm, "_s_addr"}, 32'(s_addr), 0);
    chk({nm, "_ready"}, 32'({m1_ready, m0_ready}), 0);
    chk({nm, "_rdata"}, 32'({m1_rdata, m0_rdata}), 0);
    chk({nm, "_err"}, 32'({m1_err, m0_err}), 0);
  endtask

  initial begin
    int  model_last;
    int  win, lat, ncyc;
    logic [7:0] srd;
    logic serr;
    bit  ok;

    tbl[0] = '{0, 1'b0, 16'h0010, 8'hA5, 3, 8'h00, 1'b0, 3, 8'h00, 1'b0};
    tbl[1] = '{1, 1'b1, 16'h1234, 8'h00, 1, 8'h5A, 1'b0, 1, 8'h5A, 1'b0};
    tbl[2] = '{0, 1'b1, 16'hABCD, 8'h00, 2, 8'hFF, 1'b1, 2, 8'hFF, 1'b1};
    tbl[3] = '{1, 1'b1, 16'h0042, 8'h00, 0, 8'h99, 1'b0, 4, 8'h00, 1'b1};
    tbl[4] = '{0, 1'b1, 16'h7777, 8'h00, 4, 8'h77, 1'b0, 4, 8'h77, 1'b0};
    tbl[5] = '{1, 1'b0, 16'hFFFF, 8'h3C, 5, 8'h11, 1'b0, 4, 8'h00, 1'b1};

    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    s_ready = 1'b0; s_err = 1'b0; s_rdata = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // Single-requester transfers, including timeout and ready-at-limit.
    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].who, 1'b1, tbl[i].rd, tbl[i].ad, tbl[i].wd);
      do_txn(tbl[i].who, tbl[i].lat, tbl[i].srd, tbl[i].serr, tbl[i].ncyc,
             tbl[i].erd, tbl[i].eerr, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Requester 1 pulses valid while requester 0 is being served: no transfer.
    set_req(0, 1'b1, 1'b0, 16'h0020, 8'h5C);
    do_txn(0, 3, 8'h00, 1'b0, 3, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("dropped_req");
    end

    // Simultaneous reads after reset: requester 0 first, then 1.
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0100, 8'h00);
    set_req(1, 1'b1, 1'b1, 16'h0200, 8'h00);
    do_txn(0, 2, 8'h3C, 1'b0, 2, 8'h3C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_txn(1, 1, 8'hC3, 1'b0, 1, 8'hC3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Both requesting continuously: grants alternate 01,10,01,10.
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0300, 8'h01);
    set_req(1, 1'b1, 1'b0, 16'h0400, 8'h02);
    for (int i = 0; i < 4; i++) begin
      win = i % 2;
      do_txn(win, 1, 8'(8'h10 + i), 1'b0, 1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      if (i < 3) set_req(win, 1'b1, 1'b0, 16'(16'h0300 + 16'(i)), 8'(i));
      else set_req(1 - win, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
    end

    // Reset asserted mid-transfer, then a normal transfer from requester 1.
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0033, 8'h00);
    @(negedge clk);
    chk("pre_reset_busy", 32'(s_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_quiet("async_reset");
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    s_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_quiet("post_async_idle");
    end
    set_req(1, 1'b1, 1'b0, 16'h0044, 8'h5A);
    do_txn(1, 2, 8'h00, 1'b0, 2, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Random traffic: model tracks pending requests and last winner.
    do_reset();
    model_last = 1;
    set_req(0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
    if ($urandom_range(0, 1) == 1)
      set_req(1, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
    for (int t = 0; t < 150; t++) begin
      if (req_v[0] && req_v[1]) win = (model_last == 1) ? 0 : 1;
      else win = req_v[0] ? 0 : 1;
      model_last = win;
      lat  = int'($urandom_range(0, 6));
      srd  = 8'($urandom);
      serr = 1'($urandom_range(0, 1));
      ok   = (lat != 0) && (lat <= T);
      ncyc = ok ? lat : T;
      do_txn(win, lat, srd, serr, ncyc, ok ? srd : 8'h00, ok ? serr : 1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 2; n++)
        if (!req_v[n] && $urandom_range(0, 1) == 1)
          set_req(n, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      if (!req_v[0] && !req_v[1])
        set_req(int'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                16'($urandom), 8'($urandom));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the cycle limit for a downstream response; legal range 1..65535, 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports mN_valid  input  1  (N=0,1) request from requester N; held high with stable fields until mN_ready.
REQ-005 SHALL have ports mN_read  input  1  (N=0,1) 1=read, 0=write.
REQ-006 SHALL have ports mN_addr  input  16  (N=0,1) byte register address.
REQ-007 SHALL have ports mN_wdata  input  8  (N=0,1) write byte.
REQ-008 SHALL have ports mN_rdata  output  8  (N=0,1) read byte, valid while mN_ready=1.
REQ-009 SHALL have ports mN_ready  output  1  (N=0,1) one-cycle completion pulse.
REQ-010 SHALL have ports mN_err  output  1  (N=0,1) error flag, valid while mN_ready=1.
REQ-011 SHALL have port s_valid  output  1  downstream request.
REQ-012 SHALL have port s_read  output  1  downstream direction.
REQ-013 SHALL have port s_addr  output  16  downstream address.
REQ-014 SHALL have port s_wdata  output  8  downstream write byte.
REQ-015 SHALL have port s_rdata  input  8  downstream read byte, sampled when s_ready=1.
REQ-016 SHALL have port s_ready  input  1  downstream completion, single-cycle.
REQ-017 SHALL have port s_err  input  1  downstream error, sampled when s_ready=1.
REQ-018 SHALL have port grant  output  2  one-hot owner of the bus (bit N = requester N), 00 when idle.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-020 IDLE: if any mN_valid=1, SHALL select a winner, capture its read/addr/wdata into registers, set grant, go BUSY next edge (1-cycle arbitration latency).
REQ-021 Arbitration SHALL be round-robin: single request wins; both requesting -> the requester not granted most recently wins; last-grant pointer updates only on a grant.
REQ-022 BUSY: s_valid=1 and s_read/s_addr/s_wdata SHALL come from captured registers; changes on mN inputs during BUSY SHALL be ignored.
REQ-023 BUSY with s_ready=1: SHALL latch s_rdata and s_err, go DONE.
REQ-024 BUSY timeout: 16-bit counter cleared on entry to BUSY, incremented each BUSY cycle; when it reaches TIMEOUT without s_ready, SHALL go DONE with latched err=1, rdata=8'h00.
REQ-025 s_ready and timeout in the same cycle: s_ready SHALL take precedence (real rdata/err).
REQ-026 DONE: s_valid=0; granted mN_ready=1 for exactly one cycle with mN_rdata/mN_err from latches; other requester's outputs stay 0; grant cleared; go IDLE.
REQ-027 mN_rdata and mN_err SHALL be 0 whenever mN_ready=0.
REQ-028 s_ready or s_err outside BUSY SHALL be ignored.
REQ-029 A requester re-asserting valid immediately after its completion SHALL lose to a pending other requester.
REQ-030 mN_valid dropped before grant SHALL be treated as no request (no transfer issued).

Reset
REQ-031 rst_n=0 SHALL force IDLE asynchronously, mid-transfer included, with all outputs 0, counter 0, latches 0, last-grant pointer = requester 1 (requester 0 wins first contention).
REQ-032 After rst_n release SHALL issue no downstream request until an mN_valid is sampled in IDLE.

Verification
REQ-033 m0 write addr=16'h0010 wdata=8'hA5, s_ready after 3 cycles -> s_valid 1 cycle after m0_valid for 3 cycles with s_addr=0010, s_wdata=A5; m0_ready pulse 1 cycle after s_ready, m0_err=0.
REQ-034 m0 and m1 reads asserted same cycle after reset -> m0 served first, then m1; s_rdata 8'h3C/8'hC3 returned to respective mN_rdata only.
REQ-035 Both continuously requesting for 4 transfers -> grant order 01,10,01,10.
REQ-036 TIMEOUT=4, s_ready never asserted -> s_valid high 4 cycles, m1_ready=1 with m1_err=1, m1_rdata=00.
REQ-037 s_ready in the same cycle counter reaches TIMEOUT with s_err=0, s_rdata=8'h77 -> m0_err=0, m0_rdata=77.
REQ-038 rst_n low during BUSY -> all outputs 0 immediately; post-reset single m1 request served normally.
